// File: rtl/sdcard_block_loader.sv
// sdcard_block_loader: copies a run of raw SD blocks into a word-wide
// RAM from word 0, draining block tails and re-reading failed blocks.
module sdcard_block_loader #(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 25,
  parameter bit SDHC       = 1'b1,
  parameter int MAX_RETRY  = 3
) (
  input  logic                    clk50,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             base_block,
  input  logic [ADDR_W-1:0]       word_count,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_address,
  output logic [8*WORD_BYTES-1:0] ram_data,
  input  logic                    ram_op_begun,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             error_code,
  output logic                    sd_rd,
  output logic                    sd_continue,
  output logic [31:0]             sd_addr,
  input  logic [7:0]              sd_data,
  input  logic                    sd_busy,
  input  logic                    sd_hndshk_in,
  output logic                    sd_hndshk_out,
  input  logic [15:0]             sd_error
);

  localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int WPB_LOG = $clog2(512 / WORD_BYTES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

  typedef enum logic [3:0] {
    INIT_WAIT,
    IDLE,
    READBLOCK,
    BYTE_WAIT,
    BYTE_ACK,
    WRITE,
    DRAIN,
    DONE,
    ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             base_q, base_d;
  logic [ADDR_W-1:0]       count_q, count_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W-1:0]       addr_inc;
  logic [31:0]             blk_q, blk_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [7:0]              retry_q, retry_d;
  logic [9:0]              bcnt_q, bcnt_d;
  logic [8*WORD_BYTES-1:0] data_q, data_d;
  logic [15:0]             err_q, err_d;
  logic                    dack_q, dack_d;
  logic [31:0]             blk_sum;

  assign blk_sum  = base_q + blk_q;
  assign addr_inc = addr_q + 1'b1;

  assign sd_addr     = SDHC ? blk_sum : {blk_sum[22:0], 9'd0};
  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign error_code  = err_q;
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERROR);
  assign busy        = (state_q == READBLOCK) || (state_q == BYTE_WAIT) ||
                       (state_q == BYTE_ACK) || (state_q == WRITE) ||
                       (state_q == DRAIN);

  // state and datapath registers
  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= INIT_WAIT;
      base_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      blk_q   <= '0;
      lane_q  <= '0;
      retry_q <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      err_q   <= '0;
      dack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      blk_q   <= blk_d;
      lane_q  <= lane_d;
      retry_q <= retry_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      dack_q  <= dack_d;
    end
  end

  // next-state, counter updates and strobes decoded from state
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    count_d       = count_q;
    addr_d        = addr_q;
    blk_d         = blk_q;
    lane_d        = lane_q;
    retry_d       = retry_q;
    bcnt_d        = bcnt_q;
    data_d        = data_q;
    err_d         = err_q;
    dack_d        = 1'b0;
    sd_rd         = 1'b0;
    sd_continue   = 1'b0;
    sd_hndshk_out = 1'b0;
    ram_we        = 1'b0;
    unique case (state_q)
      INIT_WAIT: begin
        if (!sd_busy) begin
          if (sd_error == 16'h0000) begin
            state_d = IDLE;
          end else begin
            err_d   = sd_error;
            state_d = ERROR;
          end
        end
      end
      IDLE, DONE: begin
        if (start) begin
          base_d  = base_block;
          count_d = word_count;
          addr_d  = '0;
          blk_d   = '0;
          lane_d  = '0;
          retry_d = '0;
          bcnt_d  = '0;
          state_d = (word_count == '0) ? DONE : READBLOCK;
        end
      end
      READBLOCK: begin
        sd_rd       = 1'b1;
        sd_continue = (blk_q != 32'd0);
        if (sd_busy) state_d = BYTE_WAIT;
      end
      BYTE_WAIT: begin
        if (sd_hndshk_in) begin
          data_d[{lane_q, 3'b000} +: 8] = sd_data;
          bcnt_d  = bcnt_q + 10'd1;
          state_d = BYTE_ACK;
        end else if (!sd_busy) begin
          if (sd_error != 16'h0000) begin
            if (int'(retry_q) < MAX_RETRY) begin
              retry_d = retry_q + 8'd1;
              addr_d  = ADDR_W'(blk_q << WPB_LOG);
              lane_d  = '0;
              bcnt_d  = '0;
              state_d = READBLOCK;
            end else begin
              err_d   = sd_error;
              state_d = ERROR;
            end
          end else if (bcnt_q == 10'd512) begin
            blk_d   = blk_q + 32'd1;
            bcnt_d  = '0;
            retry_d = '0;
            state_d = READBLOCK;
          end
        end
      end
      BYTE_ACK: begin
        sd_hndshk_out = 1'b1;
        if (!sd_hndshk_in) begin
          if (lane_q == LAST_LANE) begin
            state_d = WRITE;
          end else begin
            lane_d  = lane_q + 1'b1;
            state_d = BYTE_WAIT;
          end
        end
      end
      WRITE: begin
        ram_we = 1'b1;
        if (ram_op_begun) begin
          addr_d  = addr_inc;
          lane_d  = '0;
          state_d = (addr_inc == count_q) ? DRAIN : BYTE_WAIT;
        end
      end
      DRAIN: begin
        sd_hndshk_out = dack_q;
        dack_d        = sd_hndshk_in;
        if (!sd_busy) state_d = DONE;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        state_d = INIT_WAIT;
      end
    endcase
  end

endmodule

// File: tb/tb_sdcard_block_loader.sv
// tb_sdcard_block_loader: directed bench with a byte-handshake SD model
// and a RAM acknowledger with programmable delay.
`timescale 1ns/1ps
module tb_sdcard_block_loader;

  localparam int AW = 25;

  logic          clk50;
  logic          reset;
  logic          start;
  logic [31:0]   base_block;
  logic [AW-1:0] word_count;
  logic          ram_we;
  logic [AW-1:0] ram_address;
  logic [15:0]   ram_data;
  logic          ram_op_begun;
  logic          busy, done, error;
  logic [15:0]   error_code;
  logic          sd_rd, sd_continue;
  logic [31:0]   sd_addr;
  logic [7:0]    sd_data;
  logic          sd_busy, sd_hndshk_in, sd_hndshk_out;
  logic [15:0]   sd_error;

  logic          start2;
  logic          ram_we2;
  logic [AW-1:0] ram_address2;
  logic [15:0]   ram_data2;
  logic          busy2, done2, error2;
  logic [15:0]   error_code2;
  logic          sd_rd2, sd_continue2, sd_hndshk_out2;
  logic [31:0]   sd_addr2;

  int total = 0;
  int bad = 0;

  // SD model controls (main-owned) and logs (model-owned)
  bit          force_idle;
  bit          idle_busy;
  logic [15:0] idle_err;
  bit          stall_req;
  int          fail_blk, fail_at, fail_upto;
  int          n_fail, n_rd, hs_to;
  logic [31:0] rd_addr [64];
  bit          rd_cont [64];
  int          blk_acks [64];

  // RAM acknowledger controls and logs
  int            ack_delay;
  int            wr_n, last_wait, hold_errs, wr_viol, wcnt;
  logic [15:0]   wmem [1024];
  int            wlog [4096];
  logic [15:0]   hd;
  logic [AW-1:0] ha;

  int rb, wb, hb, vb;
  logic q;

  sdcard_block_loader #(
    .WORD_BYTES(2), .ADDR_W(AW), .SDHC(1'b1), .MAX_RETRY(1)
  ) dut (
    .clk50(clk50), .reset(reset), .start(start),
    .base_block(base_block), .word_count(word_count),
    .ram_we(ram_we), .ram_address(ram_address), .ram_data(ram_data),
    .ram_op_begun(ram_op_begun),
    .busy(busy), .done(done), .error(error), .error_code(error_code),
    .sd_rd(sd_rd), .sd_continue(sd_continue), .sd_addr(sd_addr),
    .sd_data(sd_data), .sd_busy(sd_busy), .sd_hndshk_in(sd_hndshk_in),
    .sd_hndshk_out(sd_hndshk_out), .sd_error(sd_error)
  );

  sdcard_block_loader #(
    .WORD_BYTES(2), .ADDR_W(AW), .SDHC(1'b0), .MAX_RETRY(3)
  ) dut_byteaddr (
    .clk50(clk50), .reset(reset), .start(start2),
    .base_block(32'd2), .word_count(AW'(8)),
    .ram_we(ram_we2), .ram_address(ram_address2), .ram_data(ram_data2),
    .ram_op_begun(1'b0),
    .busy(busy2), .done(done2), .error(error2), .error_code(error_code2),
    .sd_rd(sd_rd2), .sd_continue(sd_continue2), .sd_addr(sd_addr2),
    .sd_data(8'h00), .sd_busy(1'b0), .sd_hndshk_in(1'b0),
    .sd_hndshk_out(sd_hndshk_out2), .sd_error(16'h0000)
  );

  initial begin
    clk50 = 1'b0;
    forever #10 clk50 = ~clk50;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int b, input int i);
    if (i == 0) return 8'h11;
    if (i == 1) return 8'h22;
    return 8'(i) ^ 8'(b * 37);
  endfunction

  task automatic wait_hs(input logic v, output bit ok);
    int n;
    n = 0;
    while (sd_hndshk_out !== v && n < 200) begin
      @(negedge clk50);
      n++;
    end
    ok = (sd_hndshk_out === v);
    if (!ok) hs_to++;
  endtask

  // SD controller model: serves 512 bytes per read, optional failure
  initial begin
    int  blk, acks;
    bit  fl, ok;
    sd_busy = 1'b1;
    sd_error = 16'h0;
    sd_hndshk_in = 1'b0;
    sd_data = 8'h00;
    n_rd = 0;
    n_fail = 0;
    hs_to = 0;
    forever begin
      @(negedge clk50);
      if (force_idle) begin
        sd_busy = idle_busy;
        sd_error = idle_err;
      end else if (sd_rd && !sd_busy) begin
        blk = int'(sd_addr);
        rd_addr[n_rd] = sd_addr;
        rd_cont[n_rd] = sd_continue;
        sd_error = 16'h0;
        sd_busy = 1'b1;
        acks = 0;
        fl = (blk == fail_blk) && (n_fail < fail_upto);
        if (stall_req) begin
          while (stall_req) @(negedge clk50);
        end else begin
          for (int i = 0; i < 512; i++) begin
            if (fl && i == fail_at) break;
            sd_data = pat(blk, i);
            sd_hndshk_in = 1'b1;
            wait_hs(1'b1, ok);
            sd_hndshk_in = 1'b0;
            if (ok) wait_hs(1'b0, ok);
            if (!ok) break;
            acks++;
          end
          repeat (2) @(negedge clk50);
        end
        if (fl) begin
          sd_error = 16'h0042;
          n_fail++;
        end
        blk_acks[n_rd] = acks;
        n_rd++;
        sd_busy = 1'b0;
      end
    end
  end

  // RAM port: acknowledge after ack_delay waiting cycles, log writes
  initial begin
    ram_op_begun = 1'b0;
    wr_n = 0;
    wcnt = 0;
    last_wait = 0;
    hold_errs = 0;
    wr_viol = 0;
    hd = '0;
    ha = '0;
    forever begin
      @(negedge clk50);
      if (ram_we && sd_hndshk_out) wr_viol++;
      if (ram_op_begun) begin
        ram_op_begun = 1'b0;
      end else if (ram_we) begin
        if (wcnt != 0 && (ram_data !== hd || ram_address !== ha))
          hold_errs++;
        if (wcnt == 0) begin
          hd = ram_data;
          ha = ram_address;
        end
        if (wcnt >= ack_delay) begin
          wmem[ram_address[9:0]] = ram_data;
          wlog[wr_n] = int'(ram_address);
          wr_n++;
          last_wait = wcnt;
          wcnt = 0;
          ram_op_begun = 1'b1;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic run_load(input logic [31:0] b, input int wc,
                          input int limit);
    int n;
    @(negedge clk50);
    base_block = b;
    word_count = AW'(wc);
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    n = 0;
    while (!done && !error && n < limit) begin
      @(negedge clk50);
      n++;
    end
    chk("load_end", 32'(n < limit), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    base_block = '0;
    word_count = '0;
    ack_delay = 0;
    force_idle = 1'b1;
    idle_busy = 1'b1;
    idle_err = 16'h0;
    stall_req = 1'b0;
    fail_blk = -1;
    fail_at = 0;
    fail_upto = 0;

    repeat (3) @(negedge clk50);
    chk("rst_outs", 32'({ram_we, busy, done, error, sd_rd, sd_continue,
                         sd_hndshk_out}), 32'd0);
    chk("rst_ecode", 32'(error_code), 32'd0);
    chk("rst_ramaddr", 32'({ram_address, ram_data}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk50);
    chk("init_wait", 32'({busy, done, error}), 32'd0);

    idle_err = 16'h0031;
    idle_busy = 1'b0;
    repeat (3) @(negedge clk50);
    chk("init_err", 32'(error), 32'd1);
    chk("init_ecode", 32'(error_code), 32'h0031);
    base_block = 32'd7;
    word_count = AW'(4);
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    repeat (2) @(negedge clk50);
    chk("err_ignores_start", 32'({error, busy, sd_rd, done}), 32'b1000);

    start2 = 1'b1;
    @(negedge clk50);
    start2 = 1'b0;
    chk("byteaddr_sd_addr", sd_addr2, 32'h400);
    chk("byteaddr_rd", 32'({sd_rd2, sd_continue2, busy2}), 32'b101);
    chk("byteaddr_quiet", 32'({ram_we2, done2, error2, sd_hndshk_out2,
                               |ram_address2, |ram_data2, |error_code2}),
        32'd0);

    idle_err = 16'h0;
    reset = 1'b1;
    repeat (2) @(negedge clk50);
    reset = 1'b0;
    repeat (3) @(negedge clk50);
    force_idle = 1'b0;
    chk("idle_after_reset", 32'({busy, done, error}), 32'd0);

    rb = n_rd;
    wb = wr_n;
    run_load(32'd5, 256, 20000);
    chk("b_nrd", n_rd - rb, 32'd1);
    chk("b_sd_addr", rd_addr[rb], 32'd5);
    chk("b_cont", 32'(rd_cont[rb]), 32'd0);
    chk("b_nwr", wr_n - wb, 32'd256);
    chk("b_first_addr", wlog[wb], 32'd0);
    chk("b_w0", 32'(wmem[0]), 32'h2211);
    chk("b_w255", 32'(wmem[255]), 32'h4647);
    chk("b_done", 32'({done, busy}), 32'b10);

    rb = n_rd;
    wb = wr_n;
    run_load(32'd5, 300, 20000);
    chk("c_nrd", n_rd - rb, 32'd2);
    chk("c_sd_addr2", rd_addr[rb + 1], 32'd6);
    chk("c_cont2", 32'(rd_cont[rb + 1]), 32'd1);
    chk("c_nwr", wr_n - wb, 32'd300);
    chk("c_last_addr", wlog[wr_n - 1], 32'd299);
    chk("c_w299", 32'(wmem[299]), 32'h8988);
    chk("c_drained", blk_acks[rb + 1], 32'd512);

    ack_delay = 7;
    hb = hold_errs;
    vb = wr_viol;
    rb = n_rd;
    wb = wr_n;
    run_load(32'd9, 4, 5000);
    ack_delay = 0;
    chk("d_nwr", wr_n - wb, 32'd4);
    chk("d_wait", last_wait, 32'd7);
    chk("d_hold", hold_errs - hb, 32'd0);
    chk("d_no_ack_in_write", wr_viol - vb, 32'd0);
    chk("d_w0", 32'(wmem[0]), 32'h2211);
    chk("d_w3", 32'(wmem[3]), 32'h4A4B);

    stall_req = 1'b1;
    wb = wr_n;
    @(negedge clk50);
    base_block = 32'd40;
    word_count = AW'(10);
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    repeat (6) @(negedge clk50);
    chk("s_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk50);
    reset = 1'b0;
    q = 1'b0;
    repeat (5) begin
      @(negedge clk50);
      q = q | ram_we | busy | done | error;
    end
    chk("s_abort", 32'(q), 32'd0);
    stall_req = 1'b0;
    repeat (4) @(negedge clk50);
    chk("s_idle", 32'({busy, done, error}), 32'd0);
    chk("s_nwr", wr_n - wb, 32'd0);

    fail_blk = 21;
    fail_at = 100;
    fail_upto = n_fail + 1;
    rb = n_rd;
    wb = wr_n;
    run_load(32'd20, 768, 30000);
    chk("e_nrd", n_rd - rb, 32'd4);
    chk("e_retry_addr", rd_addr[rb + 2], 32'd21);
    chk("e_retry_cont", 32'(rd_cont[rb + 2]), 32'd1);
    chk("e_next_addr", rd_addr[rb + 3], 32'd22);
    chk("e_rewind", wlog[wb + 306], 32'd256);
    chk("e_nwr", wr_n - wb, 32'd818);
    chk("e_done", 32'({done, error}), 32'b10);
    chk("e_w300", 32'(wmem[300]), 32'h5051);
    chk("e_w767", 32'(wmem[767]), 32'hD1D0);

    fail_upto = n_fail + 2;
    rb = n_rd;
    wb = wr_n;
    run_load(32'd20, 768, 30000);
    chk("f_state", 32'({error, done, busy}), 32'b100);
    chk("f_code", 32'(error_code), 32'h0042);
    chk("f_nrd", n_rd - rb, 32'd3);
    chk("f_nwr", wr_n - wb, 32'd356);
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
    @(negedge clk50);
    chk("f_sticky", 32'({error, sd_rd}), 32'b10);

    chk("hs_timeouts", hs_to, 32'd0);
    chk("no_ack_in_write", wr_viol, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdcard_block_loader.md
# sdcard_block_loader

Parametrised SD-card-to-RAM bulk loader. It sits between the SdCardCtrl byte-handshake controller and a word-wide RAM write port. It copies a runtime-selected run of raw blocks into RAM starting at word 0. Compared with the fixed power-on loader, it adds configurable word width, a start/base/length command interface for repeated loads, tail-of-block draining, and per-block retry on controller error.

## Interface
- WORD_BYTES, 2, bytes per RAM word; legal values 1, 2, 4 (must divide 512)
- ADDR_W, 25, RAM word-address width
- SDHC, 1, 1: sd_addr is a block address; 0: sd_addr is a byte address (block×512)
- MAX_RETRY, 3, re-reads allowed per block before ERROR
- clk50  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle load request; sampled only in IDLE or DONE
- base_block  in  32  first SD block of the load; latched on accepted start
- word_count  in  ADDR_W  number of RAM words to write; latched on accepted start
- ram_we  out  1  write request, held until ram_op_begun
- ram_address  out  ADDR_W  word address, 0-based from load start
- ram_data  out  8×WORD_BYTES  assembled word
- ram_op_begun  in  1  RAM acknowledge
- busy  out  1  high from accepted start until DONE/ERROR
- done  out  1  high in DONE
- error  out  1  high in ERROR (sticky until reset)
- error_code  out  16  sd_error captured at final failure
- sd_rd, sd_continue  out  1  controller block-read request / multi-block continue
- sd_addr  out  32  controller address
- sd_data  in  8  controller byte
- sd_busy  in  1  controller busy
- sd_hndshk_in  in  1  controller byte-ready
- sd_hndshk_out  out  1  byte acknowledge
- sd_error  in  16  controller error status

## Operation
- States: INIT_WAIT, IDLE, READBLOCK, BYTE_WAIT, BYTE_ACK, WRITE, DRAIN, DONE, ERROR.
- INIT_WAIT (after reset):
  - sd_busy=0 and sd_error=0 → IDLE.
  - sd_busy=0 and sd_error≠0 → ERROR, error_code=sd_error.
- IDLE/DONE, start=1:
  - Latch base_block and word_count.
  - Clear the word address, block offset, byte lane and retry count.
  - If word_count=0 → DONE; else → READBLOCK.
- READBLOCK:
  - Drive sd_rd=1.
  - Drive sd_addr = base_block+blk_off if SDHC, else (base_block+blk_off)<<9.
  - sd_continue=1 when blk_off≠0.
  - On sd_busy=1 → BYTE_WAIT.
- BYTE_WAIT:
  - sd_hndshk_in=1: store sd_data into byte lane `lane` (little-endian, first byte → bits[7:0]) → BYTE_ACK.
  - sd_busy=0, sd_error=0, 512 bytes consumed: blk_off+1 → READBLOCK.
  - sd_busy=0, sd_error≠0 → retry path.
- BYTE_ACK:
  - Drive sd_hndshk_out=1 until sd_hndshk_in=0.
  - Then, if lane=WORD_BYTES−1 → WRITE; else lane+1 → BYTE_WAIT.
- WRITE:
  - Drive ram_we=1 until ram_op_begun=1.
  - On that cycle: address+1, lane=0.
  - If address+1=word_count → DRAIN; else → BYTE_WAIT.
- DRAIN:
  - Acknowledge and discard remaining bytes of the current block (same handshake as BYTE_ACK).
  - When sd_busy=0 → DONE.
  - If the block ended exactly on the last word, DRAIN sees sd_busy=0 and exits immediately.
- Retry path:
  - retry<MAX_RETRY: retry+1, rewind address to the block's first word (blk_off×512/WORD_BYTES), lane=0 → READBLOCK with the same blk_off.
  - Otherwise: latch error_code=sd_error → ERROR.
  - The retry count clears on each successful block end.
- ERROR: ignores start; only reset exits.
- Arithmetic: sd_addr sum wraps mod 2^32. The address counter is ADDR_W bits; word_count is the bound, so there is no wrap.

## Timing
- Reset values: all outputs 0; state INIT_WAIT.
- All controller/RAM strobes are combinational from state. Counters and data are registered.
- Minimum per byte: 2 cycles (BYTE_WAIT, BYTE_ACK), plus controller latency.
- Minimum per word: 2×WORD_BYTES+1 cycles.
- ram_data/ram_address are stable the whole time ram_we=1. They update the cycle after ram_op_begun.
- done and busy change the cycle after the deciding event.
- A start in the same cycle as a DONE entry is ignored.
- Reset mid-load aborts immediately; no RAM write is issued after reset.

## Test plan
- Init fail: sd_busy falls with sd_error=16'h0031 → ERROR, error_code=16'h0031, start ignored.
- WORD_BYTES=2, base_block=5, word_count=256 → one block, sd_addr=5, sd_continue=0; bytes 0x11,0x22 → ram_data=16'h2211 at address 0; done after 256 writes.
- word_count=300 → second block sd_addr=6, sd_continue=1; last write address 299; 424 tail bytes drained (acked, no ram_we).
- SDHC=0, base_block=2 → sd_addr=32'h400.
- Error on block 1 of 3, MAX_RETRY=1 → re-read from address 256; second failure → ERROR; first success → completes with 768 writes.
- ram_op_begun delayed 7 cycles → ram_we and ram_data held; no byte ack issued until after the write.
